// File: rtl/pid_pkg.sv
// Shared constants and FSM state type for the line-follower PID speed sequencer.
package pid_pkg;
    localparam logic signed [5:0] P_COEFF  = 6'sd2;
    localparam logic signed [6:0] D_COEFF  = 7'sd56;
    localparam logic        [11:0] BASE_SPD = 12'h300;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_P = 3'd1,
        MUL_D = 3'd2,
        INTG  = 3'd3,
        SUM   = 3'd4
    } state_t;
endpackage

// File: rtl/sat_signed.sv
// Two's-complement saturation from IN_W bits down to OUT_W bits (IN_W > OUT_W).
module sat_signed #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 11
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    logic [IN_W-OUT_W:0] top;

    assign top = din[IN_W-1:OUT_W-1];

    // In range exactly when every bit above the output sign bit matches it.
    always_comb begin
        if (&top || ~|top)
            dout = din[OUT_W-1:0];
        else if (din[IN_W-1])
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        else
            dout = {1'b0, {(OUT_W-1){1'b1}}};
    end
endmodule

// File: rtl/pid_seq.sv
// PID motor-speed sequencer: one error sample per pass through a 5-state FSM
// sharing a single registered multiplier for the P and D terms.
//
// state | meaning
// IDLE  | waiting for err_vld; speeds hold last result
// MUL_P | product <= err_cap * P_COEFF
// MUL_D | latch P term, product <= sat8(err_cap - hist2) * D_COEFF
// INTG  | integrator += err_cap (saturating)
// SUM   | combine terms, register speeds, shift history
module pid_seq
    import pid_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               err_vld,
    input  logic signed [15:0] error,
    output logic        [11:0] lft_spd,
    output logic        [11:0] rght_spd,
    output logic               spd_vld,
    output logic               busy,
    output logic               err_ovr
);
    state_t state, state_nxt;

    logic signed [10:0] err_sat, err_cap, hist1, hist2;
    logic signed [11:0] d_diff;
    logic signed [7:0]  d_diff_sat;
    logic signed [10:0] mul_a;
    logic signed [6:0]  mul_b;
    logic        [17:0] product;
    logic signed [14:0] p_sat, p_term, d_term;
    logic signed [15:0] integ, integ_nxt;
    logic        [16:0] integ_sum;
    logic signed [11:0] i_term;
    logic        [16:0] pid_sum;
    logic signed [14:0] pid;
    logic signed [11:0] adj;
    logic        [13:0] lft_raw, rght_raw;
    logic signed [12:0] lft_sat, rght_sat;
    logic               capture;

    sat_signed #(.IN_W(16), .OUT_W(11)) u_sat_err  (.din(error),             .dout(err_sat));
    sat_signed #(.IN_W(12), .OUT_W(8))  u_sat_diff (.din(d_diff),            .dout(d_diff_sat));
    sat_signed #(.IN_W(18), .OUT_W(15)) u_sat_p    (.din(product),           .dout(p_sat));
    sat_signed #(.IN_W(17), .OUT_W(16)) u_sat_intg (.din(integ_sum),         .dout(integ_nxt));
    sat_signed #(.IN_W(17), .OUT_W(15)) u_sat_pid  (.din(pid_sum),           .dout(pid));
    sat_signed #(.IN_W(14), .OUT_W(13)) u_sat_lft  (.din(lft_raw),           .dout(lft_sat));
    sat_signed #(.IN_W(14), .OUT_W(13)) u_sat_rght (.din(rght_raw),          .dout(rght_sat));

    assign d_diff    = {err_cap[10], err_cap} - {hist2[10], hist2};
    assign integ_sum = {integ[15], integ} + {{6{err_cap[10]}}, err_cap};
    assign d_term    = product[14:0];
    assign i_term    = integ[15:4];
    assign pid_sum   = {{2{p_term[14]}}, p_term} + {{5{i_term[11]}}, i_term}
                     + {{2{d_term[14]}}, d_term};
    assign adj       = pid[14:3];
    assign lft_raw   = {2'b00, BASE_SPD} + {{2{adj[11]}}, adj};
    assign rght_raw  = {2'b00, BASE_SPD} - {{2{adj[11]}}, adj};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!go) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (err_vld) state_nxt = MUL_P;
                MUL_P:   state_nxt = MUL_D;
                MUL_D:   state_nxt = INTG;
                INTG:    state_nxt = SUM;
                SUM:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        capture = (state == IDLE) && go && err_vld;
        mul_a   = err_cap;
        mul_b   = {P_COEFF[5], P_COEFF};
        if (state == MUL_D) begin
            mul_a = {{3{d_diff_sat[7]}}, d_diff_sat};
            mul_b = D_COEFF;
        end
    end

    // Low 18 bits of a sign-extended product are the signed 11x7 result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cap  <= '0;
            product  <= '0;
            p_term   <= '0;
            integ    <= '0;
            hist1    <= '0;
            hist2    <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
            err_ovr  <= 1'b0;
        end else if (!go) begin
            err_cap  <= '0;
            product  <= '0;
            p_term   <= '0;
            integ    <= '0;
            hist1    <= '0;
            hist2    <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            spd_vld <= 1'b0;
            err_ovr <= err_vld && (state != IDLE);
            if (capture)
                err_cap <= err_sat;
            case (state)
                MUL_P: product <= {{7{mul_a[10]}}, mul_a} * {{11{mul_b[6]}}, mul_b};
                MUL_D: begin
                    p_term  <= p_sat;
                    product <= {{7{mul_a[10]}}, mul_a} * {{11{mul_b[6]}}, mul_b};
                end
                INTG:  integ <= integ_nxt;
                SUM: begin
                    lft_spd  <= lft_sat[12]  ? 12'd0 : lft_sat[11:0];
                    rght_spd <= rght_sat[12] ? 12'd0 : rght_sat[11:0];
                    spd_vld  <= 1'b1;
                    hist2    <= hist1;
                    hist1    <= err_cap;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/pid_seq.md
PID_SEQ -- requirements
Module: pid_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all flops rising-edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: go  in  1  enable; low = idle, clear state, zero speeds.
REQ-004 SHALL have ports: err_vld  in  1  one-cycle strobe qualifying error.
REQ-005 SHALL have ports: error  in  16  signed IR error reading.
REQ-006 SHALL have ports: lft_spd  out  12  unsigned left motor speed.
REQ-007 SHALL have ports: rght_spd  out  12  unsigned right motor speed.
REQ-008 SHALL have ports: spd_vld  out  1  one-cycle pulse when speeds update.
REQ-009 SHALL have ports: busy  out  1  high from capture until spd_vld.
REQ-010 SHALL have ports: err_ovr  out  1  one-cycle pulse when err_vld is dropped.

Function
REQ-011 SHALL use constants: P_COEFF = 2 (6b signed), D_COEFF = 56 (7b signed), BASE_SPD = 12'h300.
REQ-012 SHALL compute err_sat as error saturated to 11b signed (clamp 0x3FF / 0x400).
REQ-013 SHALL run FSM IDLE -> MUL_P -> MUL_D -> INTG -> SUM -> IDLE, one cycle per state.
REQ-014 SHALL capture err_sat into err_cap and go IDLE->MUL_P on the edge where state = IDLE, go = 1 and err_vld = 1.
REQ-015 SHALL own one shared signed 11x7 multiplier: MUL_P operands = (err_cap, P_COEFF); MUL_D operands = (sign-extended D_diff_sat, D_COEFF); product is registered.
REQ-016 SHALL form P_term as the product saturated to 15b signed.
REQ-017 SHALL form D_diff = err_cap - hist2, saturated to 8b signed; D_term = product, 15b signed.
REQ-018 In INTG, SHALL add sign-extended err_cap into a 16b signed integrator, clamped to 0x7FFF / 0x8000 with no wrap.
REQ-019 SHALL take I_term = integrator >>> 4.
REQ-020 In SUM, SHALL compute pid = sat15(P_term + I_term + D_term) and adj = pid >>> 3 (arithmetic, floor).
REQ-021 In SUM, SHALL set lft_spd = clamp(BASE_SPD + adj, 0, 4095) and rght_spd = clamp(BASE_SPD - adj, 0, 4095).
REQ-022 On the SUM->IDLE edge, SHALL shift history (hist2 <= hist1, hist1 <= err_cap).
REQ-023 SHALL register speeds on the 4th rising edge after the capture edge, with spd_vld high exactly the following cycle.
REQ-024 SHALL drive busy high in every non-IDLE state.
REQ-025 SHALL ignore err_vld while busy and pulse err_ovr the next cycle; no pipelining or queueing.
REQ-026 On go = 0 in any state, SHALL return to IDLE next edge: integrator, hist1, hist2, speeds = 0, no spd_vld, busy = 0.
REQ-027 SHALL give go = 0 priority over simultaneous err_vld.
REQ-028 SHALL allow err_vld in the same cycle spd_vld is high, since state is IDLE then.

Reset
REQ-029 SHALL make all flops async-cleared on rst_n low: state = IDLE; err_cap, product, hist1, hist2, integrator = 0; lft_spd = rght_spd = 0; spd_vld = busy = err_ovr = 0.
REQ-030 SHALL abort any in-progress computation on reset mid-operation, with no spd_vld after release until a new capture.

Structure
REQ-031 SHALL place P_COEFF, D_COEFF, BASE_SPD and the FSM state enum typedef in shared package pid_pkg.
REQ-032 SHALL implement every clamp with one parameterized saturating sub-module sat_signed (input width, output width).

Verification
REQ-033 go = 1, error = 0x0010, clean state -> P = 32, D = 896, I = 1, pid = 929, adj = 116; lft_spd = 884, rght_spd = 652; spd_vld 4 edges after capture.
REQ-034 Three captures of 0x0010 -> D_term = 896, 896, 0 (history lag of two).
REQ-035 error = 0xFFF0, clean state -> pid = -929, adj = -117; lft_spd = 651, rght_spd = 885.
REQ-036 error = 0x7FFF -> err_sat = 1023, D_diff_sat = 127, pid = 9221, adj = 1152; lft_spd = 1920, rght_spd = 0 (clamped). 40 repeats -> integrator holds 0x7FFF, no wrap.
REQ-037 err_vld in MUL_D -> err_ovr pulse, result from first sample only. go dropped in INTG -> no spd_vld, speeds = 0, integrator = 0.
REQ-038 rst_n low in MUL_P -> all outputs 0 immediately, with no spd_vld after release.
